// File: rtl/module_input_deco_gray_qual.sv
// Gray-code input qualifier for front-panel switches and encoders.
// The asynchronous Gray input is synchronised and sampled on a programmable
// refresh tick. A new code is accepted after STABLE_SAMPLES consecutive equal
// samples. The accepted code is converted to binary, and each change is
// classified as a step up, a step down or a step error.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-low reset
//   gray_code_i  asynchronous Gray-coded input, WIDTH bits
//   bin_code_o   registered binary value of the accepted code
//   code_valid_o one-cycle pulse when bin_code_o takes a new value
//   dir_up_o     one-cycle pulse: new = old + 1 (mod 2^WIDTH)
//   dir_down_o   one-cycle pulse: new = old - 1 (mod 2^WIDTH)
//   step_err_o   one-cycle pulse: any other change
//
// state   | meaning
// --------+------------------------------------------------------------
// STABLE  | accepted code matches the input, waiting for a differing sample
// QUALIFY | counting consecutive equal samples of the candidate code
// COMMIT  | one cycle: candidate becomes the accepted code, pulses issued
module module_input_deco_gray_qual #(
  parameter int WIDTH          = 4,
  parameter int INPUT_REFRESH  = 2700000,
  parameter int STABLE_SAMPLES = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gray_code_i,
  output logic [WIDTH-1:0] bin_code_o,
  output logic             code_valid_o,
  output logic             dir_up_o,
  output logic             dir_down_o,
  output logic             step_err_o
);

  localparam int RW = $clog2(INPUT_REFRESH);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [RW-1:0] REFRESH_LOAD = RW'(INPUT_REFRESH - 1);
  localparam logic [CW-1:0] CNT_TARGET   = CW'(STABLE_SAMPLES);

  localparam logic [1:0] ST_STABLE  = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;
  // With a single required sample, the first differing sample commits directly.
  localparam logic [1:0] ST_AFTER_FIRST = (STABLE_SAMPLES == 1) ? ST_COMMIT : ST_QUALIFY;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [RW-1:0]    refresh_q, refresh_d;
  logic             tick_q, tick_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] delta;
  logic [CW-1:0]    cnt_inc;

  always_comb begin
    sync_d[0] = gray_code_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];

  always_comb begin
    tick_d    = (refresh_q == '0);
    refresh_d = tick_d ? REFRESH_LOAD : refresh_q - 1'b1;
  end

  assign new_bin = gray2bin(cand_q);
  assign delta   = new_bin - bin_q;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    first_d = first_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (tick_q && (sample != acc_q)) begin
          cand_d  = sample;
          cnt_d   = CW'(1);
          state_d = ST_AFTER_FIRST;
        end
      end
      ST_QUALIFY: begin
        if (tick_q) begin
          if (sample == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_TARGET) begin
              state_d = ST_COMMIT;
            end
          end else if (sample == acc_q) begin
            state_d = ST_STABLE;
          end else begin
            cand_d = sample;
            cnt_d  = CW'(1);
          end
        end
      end
      ST_COMMIT: begin
        acc_d   = cand_q;
        bin_d   = new_bin;
        valid_d = 1'b1;
        // The first accepted code after reset has no meaningful predecessor.
        if (first_q) begin
          if (delta == WIDTH'(1)) begin
            up_d = 1'b1;
          end else if (delta == {WIDTH{1'b1}}) begin
            dn_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        first_d = 1'b1;
        state_d = ST_STABLE;
      end
      default: state_d = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      refresh_q <= REFRESH_LOAD;
      tick_q    <= 1'b0;
      state_q   <= ST_STABLE;
      cand_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      refresh_q <= refresh_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      err_q     <= err_d;
    end
  end

  assign bin_code_o   = bin_q;
  assign code_valid_o = valid_q;
  assign dir_up_o     = up_q;
  assign dir_down_o   = dn_q;
  assign step_err_o   = err_q;

endmodule

// File: tb/tb_module_input_deco_gray_qual.sv
module tb_module_input_deco_gray_qual;

  localparam int W  = 4;
  localparam int R  = 8;
  localparam int SS = 3;
  localparam int S  = 2;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [W-1:0] gray_code_i;
  logic [W-1:0] bin_code_o;
  logic         code_valid_o, dir_up_o, dir_down_o, step_err_o;

  always #5 clk_i = ~clk_i;

  module_input_deco_gray_qual #(
    .WIDTH(W), .INPUT_REFRESH(R), .STABLE_SAMPLES(SS), .SYNC_STAGES(S)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .gray_code_i(gray_code_i),
    .bin_code_o(bin_code_o), .code_valid_o(code_valid_o),
    .dir_up_o(dir_up_o), .dir_down_o(dir_down_o), .step_err_o(step_err_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Binary value whose Gray encoding is g, found by search.
  function automatic int g2b(input int g);
    for (int n = 0; n < 16; n++) begin
      if ((n ^ (n >> 1)) == g) return n;
    end
    return -1;
  endfunction

  function automatic int b2g(input int n);
    return n ^ (n >> 1);
  endfunction

  // Behavioural model: the input is recorded every cycle; on each refresh
  // instant the delayed input is taken as a sample, and a code is accepted
  // once the latest SS samples agree and differ from the accepted code.
  int hist [int];
  int e = 0;
  int m_acc = 0, run_val = 0, run_len = 0, m_bin = 0;
  int s_idx, s_val, nb, dlt;
  bit m_first = 0, m_valid = 0, m_up = 0, m_dn = 0, m_err = 0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      e = 0; hist.delete();
      m_acc = 0; run_val = 0; run_len = 0; m_bin = 0; m_first = 0;
      m_valid = 0; m_up = 0; m_dn = 0; m_err = 0;
    end else begin
      e++;
      hist[e] = int'(gray_code_i);
      m_valid = 0; m_up = 0; m_dn = 0; m_err = 0;
      // Tick k is registered at cycle k*R, consumed one cycle later,
      // and its result is visible one cycle after that.
      if (e >= R + 2 && (e - 2) % R == 0) begin
        s_idx = e - 1 - S;
        s_val = hist.exists(s_idx) ? hist[s_idx] : 0;
        if (run_len > 0 && s_val == run_val) run_len++;
        else begin run_val = s_val; run_len = 1; end
        if (run_len >= SS && run_val != m_acc) begin
          nb = g2b(run_val);
          if (m_first) begin
            dlt = (nb - m_bin + 16) % 16;
            if (dlt == 1) m_up = 1;
            else if (dlt == 15) m_dn = 1;
            else m_err = 1;
          end
          m_bin = nb; m_acc = run_val; m_valid = 1; m_first = 1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    logic [3:0] mb;
    mb = m_bin[3:0];
    vectors++;
    if ({bin_code_o, code_valid_o, dir_up_o, dir_down_o, step_err_o} !==
        {mb, m_valid, m_up, m_dn, m_err}) begin
      miscompares++;
      $display("FAIL cycle_model t=%0t: got bin=%0d v=%b u=%b d=%b e=%b, expected bin=%0d v=%b u=%b d=%b e=%b",
               $time, bin_code_o, code_valid_o, dir_up_o, dir_down_o, step_err_o,
               mb, m_valid, m_up, m_dn, m_err);
    end
  end

  int n_valid = 0, n_up = 0, n_dn = 0, n_err = 0;
  always @(negedge clk_i) begin
    if (code_valid_o === 1'b1) n_valid++;
    if (dir_up_o === 1'b1)     n_up++;
    if (dir_down_o === 1'b1)   n_dn++;
    if (step_err_o === 1'b1)   n_err++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_up = 0; n_dn = 0; n_err = 0;
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      step(1);
      if (code_valid_o === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic sync_after_tick();
    for (int i = 0; i < 3 * R; i++) begin
      step(1);
      if (e > R && e % R == 1) return;
    end
    check("tick_sync_timeout", 0, 1);
  endtask

  int cyc;

  initial begin
    rst_i = 1'b1;
    gray_code_i = '0;
    #1 rst_i = 1'b0;
    step(3);
    rst_i = 1'b1;

    // Idle with code 0 held: nothing ever happens.
    clear_counts();
    step(100);
    check("idle_valid", n_valid, 0);
    check("idle_bin", int'(bin_code_o), 0);

    // Forward walk 1..15, 0.
    clear_counts();
    for (int n = 1; n <= 16; n++) begin
      gray_code_i = 4'(b2g(n % 16));
      step(40);
    end
    check("fwd_valid", n_valid, 16);
    check("fwd_up", n_up, 15);
    check("fwd_down", n_dn, 0);
    check("fwd_err", n_err, 0);
    check("fwd_bin", int'(bin_code_o), 0);

    // Reverse walk 15..0.
    clear_counts();
    for (int n = 15; n >= 0; n--) begin
      gray_code_i = 4'(b2g(n));
      step(40);
    end
    check("rev_valid", n_valid, 16);
    check("rev_down", n_dn, 16);
    check("rev_up", n_up, 0);
    check("rev_err", n_err, 0);

    // Glitch rejection around accepted Gray 0011 (bin 2).
    gray_code_i = 4'b0011;
    step(40);
    check("glitch_setup_bin", int'(bin_code_o), 2);
    clear_counts();
    gray_code_i = 4'b0010;
    step(12);
    gray_code_i = 4'b0011;
    step(40);
    check("glitch_valid", n_valid, 0);
    check("glitch_bin", int'(bin_code_o), 2);

    // Jump from bin 2 to Gray 1100 (bin 8).
    clear_counts();
    gray_code_i = 4'b1100;
    wait_valid(40, cyc);
    check("jump_bin", int'(bin_code_o), 8);
    check("jump_err_now", int'(step_err_o), 1);
    step(20);
    check("jump_valid", n_valid, 1);
    check("jump_err", n_err, 1);
    check("jump_updown", n_up + n_dn, 0);

    // Latency: change one cycle after a tick, Gray 1101 (bin 9).
    sync_after_tick();
    clear_counts();
    gray_code_i = 4'b1101;
    wait_valid(40, cyc);
    check("latency_cycles", cyc, 25);
    check("latency_bin", int'(bin_code_o), 9);
    check("latency_up", n_up, 1);
    step(10);

    // Reset during QUALIFY after two matching samples of Gray 1111 (bin 10).
    sync_after_tick();
    clear_counts();
    gray_code_i = 4'b1111;
    step(2 * R + 1);
    rst_i = 1'b0;
    step(5);
    check("rst_no_pulse", n_valid, 0);
    check("rst_bin", int'(bin_code_o), 0);
    clear_counts();
    rst_i = 1'b1;
    wait_valid(40, cyc);
    check("rst_restart_latency", cyc, 26);
    check("rst_restart_bin", int'(bin_code_o), 10);
    check("rst_restart_dirs", n_up + n_dn + n_err, 0);
    step(20);
    check("rst_restart_valid", n_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/module_input_deco_gray_qual.md
Name: module_input_deco_gray_qual

Overview:
- Parametrised successor of the front-panel Gray input decoder.
- Synchronises a WIDTH-bit Gray code and samples it on a programmable refresh tick.
- Debounces it by requiring STABLE_SAMPLES consecutive equal samples, converts the accepted code to binary for any WIDTH, and classifies each accepted change as step-up, step-down or step error.
- Sits between the switch/encoder pins and the display/control logic.

Parameters:
- WIDTH, 4, Gray/binary code width (>=1).
- INPUT_REFRESH, 2700000, clock cycles between sample ticks (>=2).
- STABLE_SAMPLES, 3, consecutive equal samples required to accept a new code (>=1).
- SYNC_STAGES, 2, input synchroniser flops (>=2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- gray_code_i  in  WIDTH  asynchronous Gray-coded input.
- bin_code_o  out  WIDTH  binary value of the accepted code, registered.
- code_valid_o  out  1  one-cycle pulse when bin_code_o takes a new value.
- dir_up_o  out  1  one-cycle pulse, new = old+1 mod 2^WIDTH.
- dir_down_o  out  1  one-cycle pulse, new = old-1 mod 2^WIDTH.
- step_err_o  out  1  one-cycle pulse, any other difference.

Behaviour:
- Reset (rst_i=0, async): sync chain, candidate, accepted Gray, stable count and all outputs go to 0. Refresh counter loads INPUT_REFRESH-1. FSM enters STABLE. first_done is cleared.
- Synchroniser: SYNC_STAGES flops. The sample point is the last stage.
- Refresh counter: decrements each cycle. At 0 it reloads INPUT_REFRESH-1 and sets the registered tick for one cycle. The period is exactly INPUT_REFRESH cycles. The first tick occurs INPUT_REFRESH cycles after reset release.
- FSM:
  - STABLE: on a tick, if sample != accepted, set candidate <= sample and cnt <= 1. If STABLE_SAMPLES==1, go to COMMIT; otherwise go to QUALIFY. If sample == accepted, stay.
  - QUALIFY:
    - On a tick with sample == candidate: cnt++. If cnt+1 == STABLE_SAMPLES, go to COMMIT.
    - On a tick with sample != candidate and sample == accepted: go to STABLE (glitch rejected, no output).
    - On a tick with any other sample: candidate <= sample, cnt <= 1, stay in QUALIFY.
  - COMMIT (exactly one cycle):
    - accepted <= candidate.
    - bin_code_o <= gray2bin(candidate).
    - code_valid_o = 1 and the direction pulse are registered so they are high in the cycle after COMMIT, aligned with the new bin_code_o.
    - Return to STABLE.
    - A tick cannot coincide with COMMIT because INPUT_REFRESH>=2; if one did, it is ignored.
- gray2bin, generic: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i]. This must match the 4-bit table, e.g. 1000 -> 1111.
- Direction: delta = new_bin - bin_code_o, taken mod 2^WIDTH.
  - delta == 1 -> dir_up_o.
  - delta == 2^WIDTH-1 -> dir_down_o.
  - Otherwise -> step_err_o.
  - Exactly one of the three pulses fires with each code_valid_o.
  - WIDTH==1: delta==1 is reported as up.
  - Wrap: 1111->0000 is up; 0000->1111 is down.
- First commit after reset: code_valid_o pulses but all three direction outputs stay 0. first_done is set.
- Latency: input change to code_valid_o is at most SYNC_STAGES + INPUT_REFRESH*STABLE_SAMPLES + 2 cycles.
- Outputs hold between pulses. No pulse ever occurs without a change of the accepted code.
- Reset asserted mid-QUALIFY or mid-COMMIT aborts immediately with no pulse. After release, operation restarts from the reset state.

Test Plan (WIDTH=4, INPUT_REFRESH=8, STABLE_SAMPLES=3, SYNC_STAGES=2):
1. Reset with gray_code_i=0000 held, then release -> all outputs 0 forever, no pulses.
2. Exhaustive walk, Gray 0000->0001->0011->...->1000->0000, each held 40 cycles:
   - bin_code_o steps 0,1,...,15,0.
   - The first change gives code_valid_o only.
   - Later changes give dir_up_o with each code_valid_o, including 15->0.
   - Reverse walk gives dir_down_o, including 0->15.
3. Glitch: from accepted 0011 (bin 2), drive 0010 for 12 cycles (covers 1-2 ticks), then return to 0011 -> no pulses, bin_code_o stays 0010.
4. Jump: accepted bin 2, drive Gray 1100 (bin 8) steady -> after 3 ticks, bin_code_o=1000 with code_valid_o and step_err_o pulses, and no up or down pulse.
5. Latency: change the input one cycle after a tick -> code_valid_o asserts within 2+24+2 cycles and no earlier than the third tick after the change.
6. Reset asserted during QUALIFY (after 2 matching samples), then released with the input still changed -> no pulse before release. After release, the first commit occurs 3 ticks later with no direction or error pulse.
